lsu_align_ctrl: RTL and testbench
=================================

Name: lsu_align_ctrl

Overview:
- Load/store access controller between the pipeline memory stage and the word-organised data RAM.
- Accepts one load/store request at a time over a valid/ready handshake and issues RAM operations using the RAM's byte/half/word modes.
- Splits accesses that the RAM cannot perform in one operation into byte beats, then reassembles and sign-extends load data.
- Returns a single-cycle response pulse per request.

Parameters:
- ADDR_W, 32, request/RAM address width.
- DATA_W, 32, data width. Fixed; only 32 is supported.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle, request accepted when valid&ready.
- req_we  in  1  1=store, 0=load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_mode  in  2  0:byte, 1:half, 2:word, 3:invalid.
- req_signed  in  1  load sign-extension: 1=signed, 0=unsigned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid.
- ram_we  out  1  RAM write enable.
- ram_r_addr  out  32  RAM read address.
- ram_w_addr  out  32  RAM write address (same value as ram_r_addr).
- ram_w_data  out  32  RAM write data.
- ram_write_mode  out  2  RAM write mode.
- ram_read_mode  out  2  RAM read mode.
- ram_read_signed  out  1  RAM sign-extension select.
- ram_r_data  in  32  RAM registered read data; valid the cycle after the address is presented with ram_we=0.

Behaviour:
Reset values:
- All outputs 0 except req_ready=1.
- State IDLE.
- Internal assembly register and beat counter cleared.

Classification, latched at accept:
- Aligned (one RAM op): byte at any offset; half at offset 0–2; word at offset 0.
- Split: half at offset 3 (2 byte beats); word at offset 1–3 (4 byte beats).
- Mode 3: no RAM access; response with resp_err=1 and rdata 0.

States:
- IDLE: req_ready=1. On accept, latch the request and go to ISSUE with beat k=0. Mode 3 goes directly to RESP.
- ISSUE: drive the RAM for beat k.
  - Address = addr+k (aligned: k=0), 32-bit wrap-around.
  - Split beats use BYTE mode, read_signed=0, w_data = byte k of req_wdata in bits [7:0].
  - Aligned ops pass req_mode/req_signed/req_wdata through unchanged.
  - Store: ram_we=1 for exactly this cycle. Then next beat ISSUE, or RESP after the last beat.
  - Load: ram_we=0, go to CAPTURE.
- CAPTURE: ram_r_data valid.
  - Aligned: latch the full word.
  - Split: latch ram_r_data[7:0] into assembly bits [8k+7:8k], little-endian.
  - Then next ISSUE, or RESP.
- RESP: resp_valid=1 for one cycle, return to IDLE. req_ready stays 0 in RESP.
  - Split half loads: sign-extend bit 15 if req_signed, else zero-extend.
  - Split word loads: no extension.

Latency (accept cycle = 0; resp_valid cycle):
- Aligned load: 3.
- Aligned store: 2.
- Split half load: 5. Split word load: 9.
- Split half store: 3. Split word store: 5.
- Mode 3: 1.

Rules:
- ram_* outputs are registered or state-decoded; ram_we is never 1 outside ISSUE.
- ram_r_addr and ram_w_addr are held stable through CAPTURE.
- A request arriving while busy is not accepted; the requester must hold req_valid and its fields until the handshake completes.
- Reset mid-operation aborts to IDLE immediately (asynchronous), with ram_we forced 0. Beats already written stay written; no response is produced.
- Back-to-back: a new request may be accepted in the IDLE cycle immediately after RESP.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined: split-class requests perform no RAM access. They go IDLE→RESP with resp_err=1 and resp_rdata=0.
- Undefined: split-class requests execute as split beats as above; resp_err is asserted only for mode 3.

Decomposition:
- Shared defines header, alongside the existing RAM mode defines: RAM_MODE_BYTE/HALF/WORD (0/1/2), LSU state encodings (IDLE, ISSUE, CAPTURE, RESP).
- One sub-module: lsu_byte_assembler. Holds the assembly register with a byte-lane write at index k, plus final zero/sign extension by mode and signed flag.

Test Plan:
- Aligned word store then load: store 0xDEADBEEF to 0x100, then load word from 0x100 → rdata 0xDEADBEEF at cycle 3; resp_err=0.
- Signed aligned byte: preload 0x100=0x000080FF; load byte signed at 0x101 → 0xFFFFFF80; unsigned → 0x00000080.
- Split word load: bytes 0x100–0x107 = 00 11 22 33 44 55 66 77; load word at 0x103 → 0x66554433, resp_valid at cycle 9, exactly 4 RAM reads observed.
- Split half store + signed load: store half 0x8001 at 0x103 → mem 0x100 byte3=0x01, mem 0x104 byte0=0x80; signed half load at 0x103 → 0xFFFF8001.
- Mode 3 request → resp_valid at cycle 1, resp_err=1, no ram_we. With LSU_MISALIGN_TRAP_EN, word load at 0x102 → resp_err=1, no RAM access.
- Reset asserted during the third beat of a split word store at 0x101 → ram_we drops immediately, req_ready=1, no resp_valid; bytes 0x101–0x102 written, 0x103–0x104 unchanged.

Source files
------------

// File: rtl/lsu_align_ctrl_pkg.sv
// Shared RAM access modes, LSU state encodings and access classification
// for the load/store alignment controller.
package lsu_align_ctrl_pkg;

  localparam logic [1:0] RAM_MODE_BYTE    = 2'd0;
  localparam logic [1:0] RAM_MODE_HALF    = 2'd1;
  localparam logic [1:0] RAM_MODE_WORD    = 2'd2;
  localparam logic [1:0] REQ_MODE_INVALID = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } lsu_state_e;

  // Accesses the RAM cannot perform in one op: half crossing the word, any unaligned word.
  function automatic logic is_split(input logic [1:0] mode, input logic [1:0] offset);
    return ((mode == RAM_MODE_HALF) && (offset == 2'd3)) ||
           ((mode == RAM_MODE_WORD) && (offset != 2'd0));
  endfunction

endpackage

// File: rtl/lsu_align_ctrl_byte_assembler.sv
// Load-data assembly register: byte-lane capture for split beats, full-word
// capture for aligned ops, and final zero/sign extension of split halves.
module lsu_byte_assembler
  import lsu_align_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              capture,
  input  logic              split,
  input  logic [1:0]        beat,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [1:0]        mode,
  input  logic              signed_ld,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] asm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q <= '0;
    end else if (clear) begin
      asm_q <= '0;
    end else if (capture) begin
      if (split) asm_q[{beat, 3'b000} +: 8] <= rd_data[7:0];
      else       asm_q <= rd_data;
    end
  end

  // Aligned data arrives already extended by the RAM; only split halves need it here.
  always_comb begin
    result = asm_q;
    if (split && (mode == RAM_MODE_HALF)) begin
      result = signed_ld ? {{(DATA_W-16){asm_q[15]}}, asm_q[15:0]}
                         : {{(DATA_W-16){1'b0}}, asm_q[15:0]};
    end
  end

endmodule

// File: rtl/lsu_align_ctrl.sv
// Load/store alignment controller: one request at a time, split into byte beats
// where needed. Define LSU_MISALIGN_TRAP_EN to reject split accesses with resp_err.
module lsu_align_ctrl
  import lsu_align_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_mode,
  input  logic              req_signed,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_r_addr,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic [DATA_W-1:0] ram_w_data,
  output logic [1:0]        ram_write_mode,
  output logic [1:0]        ram_read_mode,
  output logic              ram_read_signed,
  input  logic [DATA_W-1:0] ram_r_data
);

  lsu_state_e        state, state_nxt;
  logic              we_q, signed_q, split_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        mode_q, beat_q;
  logic [1:0]        last_idx;
  logic              last_beat, accept, req_split, req_err, capture_en;
  logic [ADDR_W-1:0] beat_addr;
  logic [DATA_W-1:0] asm_result;

  assign accept    = (state == ST_IDLE) && req_valid;
  assign req_split = is_split(req_mode, req_addr[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_err = (req_mode == REQ_MODE_INVALID) || req_split;
`else
  assign req_err = (req_mode == REQ_MODE_INVALID);
`endif

  assign last_idx   = split_q ? ((mode_q == RAM_MODE_HALF) ? 2'd1 : 2'd3) : 2'd0;
  assign last_beat  = (beat_q == last_idx);
  assign beat_addr  = addr_q + {{(ADDR_W-2){1'b0}}, beat_q};
  assign capture_en = (state == ST_CAPTURE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (req_valid) state_nxt = req_err ? ST_RESP : ST_ISSUE;
      ST_ISSUE: begin
        if (!we_q)          state_nxt = ST_CAPTURE;
        else if (last_beat) state_nxt = ST_RESP;
      end
      ST_CAPTURE: state_nxt = last_beat ? ST_RESP : ST_ISSUE;
      ST_RESP:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      split_q  <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mode_q   <= RAM_MODE_BYTE;
      beat_q   <= 2'd0;
    end else if (accept) begin
      we_q     <= req_we;
      signed_q <= req_signed;
      split_q  <= req_split;
      err_q    <= req_err;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      mode_q   <= req_mode;
      beat_q   <= 2'd0;
    end else if (((state == ST_ISSUE) && we_q && !last_beat) ||
                 ((state == ST_CAPTURE) && !last_beat)) begin
      beat_q <= beat_q + 2'd1;
    end
  end

  // RAM outputs are decoded from state, so an async reset drops ram_we at once.
  always_comb begin
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    resp_err        = 1'b0;
    resp_rdata      = '0;
    ram_we          = 1'b0;
    ram_r_addr      = '0;
    ram_w_data      = '0;
    ram_write_mode  = RAM_MODE_BYTE;
    ram_read_mode   = RAM_MODE_BYTE;
    ram_read_signed = 1'b0;
    case (state)
      ST_IDLE: req_ready = 1'b1;
      ST_ISSUE, ST_CAPTURE: begin
        ram_we     = (state == ST_ISSUE) && we_q;
        ram_r_addr = beat_addr;
        if (split_q) begin
          ram_w_data = {{(DATA_W-8){1'b0}}, wdata_q[{beat_q, 3'b000} +: 8]};
        end else begin
          ram_w_data      = wdata_q;
          ram_write_mode  = mode_q;
          ram_read_mode   = mode_q;
          ram_read_signed = signed_q;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || we_q) ? '0 : asm_result;
      end
      default: ;
    endcase
  end

  assign ram_w_addr = ram_r_addr;

  lsu_byte_assembler #(.DATA_W(DATA_W)) u_byte_assembler (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .capture   (capture_en),
    .split     (split_q),
    .beat      (beat_q),
    .rd_data   (ram_r_data),
    .mode      (mode_q),
    .signed_ld (signed_q),
    .result    (asm_result)
  );

endmodule

// File: tb/tb_lsu_align_ctrl.sv
// Self-checking bench for lsu_align_ctrl: byte-addressed RAM model, reference
// memory model computed from access rules, directed literals plus random traffic.
module tb_lsu_align_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_mode;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        ram_we, ram_read_signed;
  logic [31:0] ram_r_addr, ram_w_addr, ram_w_data;
  logic [1:0]  ram_write_mode, ram_read_mode;
  logic [31:0] ram_r_data = 32'd0;

  always #5 clk = ~clk;

  lsu_align_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mode(req_mode),
    .req_signed(req_signed),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_we(ram_we), .ram_r_addr(ram_r_addr), .ram_w_addr(ram_w_addr),
    .ram_w_data(ram_w_data), .ram_write_mode(ram_write_mode),
    .ram_read_mode(ram_read_mode), .ram_read_signed(ram_read_signed),
    .ram_r_data(ram_r_data)
  );

  logic [7:0] ram_mem [0:1023];
  logic [7:0] ref_mem [0:1023];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic        pending = 1'b0;
  int          acc_cyc, exp_lat, exp_wr, wr_cnt;
  logic [31:0] exp_rdata;
  logic        exp_err;
  logic [31:0] last_rdata;
  logic        last_err;
  int          last_lat;

  function automatic logic [9:0] ix(input logic [31:0] a);
    return a[9:0];
  endfunction

  function automatic int nbytes(input logic [1:0] m);
    return (m == 2'd0) ? 1 : (m == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] v, input int nb, input logic sg);
    if (nb == 1) return sg ? {{24{v[7]}}, v[7:0]} : {24'd0, v[7:0]};
    if (nb == 2) return sg ? {{16{v[15]}}, v[15:0]} : {16'd0, v[15:0]};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // RAM environment: registered read shaped by read mode, writes by write mode.
  always @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < nbytes(ram_write_mode); i++)
        ram_mem[ix(ram_w_addr + i)] <= ram_w_data[8*i +: 8];
    end else begin
      logic [31:0] v;
      v = 32'd0;
      for (int i = 0; i < nbytes(ram_read_mode); i++)
        v[8*i +: 8] = ram_mem[ix(ram_r_addr + i)];
      ram_r_data <= ext(v, nbytes(ram_read_mode), ram_read_signed);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Every-cycle compare against the expectation posted at accept time.
  always @(negedge clk) begin
    if (!rst) begin
      chk("addr_equal", ram_w_addr, ram_r_addr);
      chk("we_while_ready_or_resp", {31'd0, ram_we & (req_ready | resp_valid)}, 32'd0);
      if (ram_we) begin
        if (pending) wr_cnt = wr_cnt + 1;
        else begin
          checks++; errors++;
          $display("FAIL stray_write: ram_we=1 with no request outstanding, expected 0");
        end
      end
      if (resp_valid) begin
        last_rdata = resp_rdata;
        last_err   = resp_err;
        last_lat   = cyc - acc_cyc;
        if (!pending) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding, expected 0");
        end else begin
          chk("latency", last_lat, exp_lat);
          chk("rdata", resp_rdata, exp_rdata);
          chk("err", {31'd0, resp_err}, {31'd0, exp_err});
          chk("ram_writes", wr_cnt, exp_wr);
          pending = 1'b0;
        end
      end else if (pending && ((cyc - acc_cyc) > exp_lat)) begin
        checks++; errors++;
        $display("FAIL resp_timeout: no resp_valid by cycle %0d, expected at %0d", cyc - acc_cyc, exp_lat);
        pending = 1'b0;
      end
    end
  end

  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] m, input logic sg);
    int nb, beats;
    logic split, err;
    logic [31:0] v;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_mode = m; req_signed = sg;
    for (int t = 0; t < 50 && !req_ready; t++) @(negedge clk);
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready=0 after 50 cycles, expected 1");
      req_valid = 1'b0;
      return;
    end
    nb    = nbytes(m);
    split = ((m == 2'd1) && (a[1:0] == 2'd3)) || ((m == 2'd2) && (a[1:0] != 2'd0));
    err   = (m == 2'd3);
`ifdef LSU_MISALIGN_TRAP_EN
    if (split) err = 1'b1;
`endif
    beats   = split ? nb : 1;
    exp_lat = err ? 1 : (we ? beats + 1 : 2 * beats + 1);
    exp_wr  = (!err && we) ? beats : 0;
    exp_err = err;
    exp_rdata = 32'd0;
    if (!err && !we) begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[ix(a + i)];
      exp_rdata = ext(v, nb, sg);
    end
    if (!err && we)
      for (int i = 0; i < nb; i++) ref_mem[ix(a + i)] = wd[8*i +: 8];
    acc_cyc = cyc;
    wr_cnt  = 0;
    pending = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_mode = 2'($urandom);
    for (int t = 0; t < 40 && pending; t++) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [31:0] a;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_mode = 2'd0; req_signed = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      b = 8'($urandom);
      ram_mem[i] = b;
      ref_mem[i] = b;
    end
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_ram_addr", ram_r_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_req(1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0);
    chk("aligned_store_lat", last_lat, 32'd2);
    do_req(1'b0, 32'h100, 32'd0, 2'd2, 1'b0);
    chk("aligned_load_data", last_rdata, 32'hDEADBEEF);
    chk("aligned_load_lat", last_lat, 32'd3);

    do_req(1'b1, 32'h100, 32'h000080FF, 2'd2, 1'b0);
    do_req(1'b0, 32'h101, 32'd0, 2'd0, 1'b1);
    chk("byte_signed", last_rdata, 32'hFFFFFF80);
    do_req(1'b0, 32'h101, 32'd0, 2'd0, 1'b0);
    chk("byte_unsigned", last_rdata, 32'h00000080);

    do_req(1'b1, 32'h100, 32'h33221100, 2'd2, 1'b0);
    do_req(1'b1, 32'h104, 32'h77665544, 2'd2, 1'b0);
`ifndef LSU_MISALIGN_TRAP_EN
    do_req(1'b0, 32'h103, 32'd0, 2'd2, 1'b0);
    chk("split_word_load", last_rdata, 32'h66554433);
    chk("split_word_lat", last_lat, 32'd9);

    do_req(1'b1, 32'h103, 32'h00008001, 2'd1, 1'b0);
    chk("split_half_store_lat", last_lat, 32'd3);
    chk("split_half_mem103", {24'd0, ram_mem[10'h103]}, 32'h01);
    chk("split_half_mem104", {24'd0, ram_mem[10'h104]}, 32'h80);
    do_req(1'b0, 32'h103, 32'd0, 2'd1, 1'b1);
    chk("split_half_signed", last_rdata, 32'hFFFF8001);
    chk("split_half_lat", last_lat, 32'd5);
`else
    do_req(1'b0, 32'h102, 32'd0, 2'd2, 1'b0);
    chk("trap_err", {31'd0, last_err}, 32'd1);
    chk("trap_lat", last_lat, 32'd1);
`endif

    do_req(1'b1, 32'h100, 32'h12345678, 2'd3, 1'b0);
    chk("mode3_err", {31'd0, last_err}, 32'd1);
    chk("mode3_lat", last_lat, 32'd1);
    chk("mode3_rdata", last_rdata, 32'd0);

    do_req(1'b0, 32'hFFFFFFFF, 32'd0, 2'd2, 1'b1);

`ifndef LSU_MISALIGN_TRAP_EN
    do_req(1'b1, 32'h100, 32'h00000000, 2'd2, 1'b0);
    do_req(1'b1, 32'h104, 32'h00000000, 2'd2, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h101; req_wdata = 32'hA4A3A2A1;
    req_mode = 2'd2; req_signed = 1'b0;
    chk("abort_ready_before", {31'd0, req_ready}, 32'd1);
    acc_cyc = cyc; exp_lat = 5; exp_wr = 4; exp_err = 1'b0; exp_rdata = 32'd0;
    wr_cnt = 0; pending = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_beat3_we", {31'd0, ram_we}, 32'd1);
    chk("abort_beat3_addr", ram_w_addr, 32'h103);
    #2;
    rst = 1'b1;
    pending = 1'b0;
    #1;
    chk("abort_we_drop", {31'd0, ram_we}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_mem101", {24'd0, ram_mem[10'h101]}, 32'hA1);
    chk("abort_mem102", {24'd0, ram_mem[10'h102]}, 32'hA2);
    chk("abort_mem103", {24'd0, ram_mem[10'h103]}, 32'h00);
    chk("abort_mem104", {24'd0, ram_mem[10'h104]}, 32'h00);
    ref_mem[10'h101] = 8'hA1;
    ref_mem[10'h102] = 8'hA2;
`endif

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) a = 32'hFFFFFFFC + $urandom_range(0, 3);
      else                           a = 32'h200 + $urandom_range(0, 31);
      do_req(1'($urandom), a, $urandom, 2'($urandom_range(0, 3)), 1'($urandom));
    end

    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 1024; i++) if (ram_mem[i] !== ref_mem[i]) bad++;
      chk("final_mem_mismatch_bytes", bad, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
